// File: rtl/prng_pkg.sv
// Shared constants and the output permutation of the 16-bit LCG noise generator.
package prng_pkg;

  localparam logic [15:0] DEFAULT_SEED = 16'd4356;
  localparam logic [15:0] LCG_MULT     = 16'd12829;
  localparam logic [15:0] LCG_INC      = 16'd47989;
  localparam logic [15:0] PERM_MULT    = 16'd62169;

  // Xorshift by 3..10 chosen from the top state bits, then a multiplicative scramble.
  function automatic logic [7:0] prng_out(input logic [15:0] s,
                                          input logic [15:0] mult = PERM_MULT);
    logic [3:0]  sh;
    logic [15:0] x;
    logic [15:0] p;
    sh = {1'b0, s[15:13]} + 4'd3;
    x  = (s >> sh) ^ s;
    p  = x * mult;
    return p[15:8];
  endfunction

  function automatic logic [15:0] lcg_next(input logic [15:0] s,
                                           input logic [15:0] mult,
                                           input logic [15:0] inc);
    return s * mult + inc;
  endfunction

endpackage

// File: rtl/prng_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o
);

  always_comb begin
    logic            found;
    int unsigned     c;
    logic [PtrW-1:0] k;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      c = (ptr_i + i) % N;
      k = PtrW'(c);
      if (!found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = k;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_share_arbiter.sv
// Shares one LCG noise generator among NUM_REQ consumers with round-robin grants.
module prng_share_arbiter
  import prng_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter logic [15:0] SEED     = DEFAULT_SEED,
  parameter logic [15:0] MULT     = LCG_MULT,
  parameter logic [15:0] INC      = LCG_INC,
  parameter logic [15:0] OUT_MULT = PERM_MULT,
  parameter bit          FREE_RUN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [7:0]         rnd_o,
  input  logic               seed_valid_i,
  input  logic [15:0]        seed_i,
  output logic               busy_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [15:0]        state_q, state_d, state_next;
  logic [7:0]         rnd_q, rnd_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] arb_req;
  logic [PtrW-1:0]    arb_idx;

  // A reseed cycle suppresses the grant so nobody consumes a byte of the old sequence.
  assign arb_req = seed_valid_i ? '0 : (req_i & ~mask_i);

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req_i(arb_req),
    .ptr_i(ptr_q),
    .gnt_o(gnt_o),
    .idx_o(arb_idx)
  );

  assign rnd_o  = rnd_q;
  assign busy_o = |gnt_o;

  // rnd_q holds f(state) precomputed so no multiplier sits on the rnd_o path.
  always_comb begin
    state_next = lcg_next(state_q, MULT, INC);
    state_d    = state_q;
    rnd_d      = rnd_q;
    ptr_d      = ptr_q;
    if (seed_valid_i) begin
      state_d = seed_i;
      rnd_d   = prng_out(seed_i, OUT_MULT);
    end else if ((|gnt_o) || FREE_RUN) begin
      state_d = state_next;
      rnd_d   = prng_out(state_next, OUT_MULT);
      if (|gnt_o) ptr_d = arb_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      rnd_q   <= prng_out(SEED, OUT_MULT);
      ptr_q   <= PtrW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_prng_share_arbiter.sv
// Bench: two DUTs (FREE_RUN 0 and 1) driven together, checked against a behavioural model.
module tb_prng_share_arbiter;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_i, mask_i;
  logic         seed_valid_i;
  logic [15:0]  seed_i;
  logic [N-1:0] gnt0, gnt1;
  logic [7:0]   rnd0, rnd1;
  logic         busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prng_share_arbiter #(.NUM_REQ(N), .FREE_RUN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req_i), .mask_i(mask_i), .gnt_o(gnt0), .rnd_o(rnd0),
    .seed_valid_i(seed_valid_i), .seed_i(seed_i), .busy_o(busy0)
  );

  prng_share_arbiter #(.NUM_REQ(N), .FREE_RUN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req_i), .mask_i(mask_i), .gnt_o(gnt1), .rnd_o(rnd1),
    .seed_valid_i(seed_valid_i), .seed_i(seed_i), .busy_o(busy1)
  );

  // ---------------- behavioural model ----------------
  function automatic int f_model(input int s);
    int     sh;
    longint x, p;
    sh = s / 8192 + 3;
    x  = longint'((s >> sh) ^ s);
    p  = (x * 62169) % 65536;
    return int'(p / 256);
  endfunction

  function automatic int next_model(input int s);
    return (s * 12829 + 47989) % 65536;
  endfunction

  // Returns the index granted, or -1 for none.
  function automatic int winner(input int ptr, input logic [N-1:0] req,
                                input logic [N-1:0] mask, input logic sv);
    if (sv) return -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (req[k] && !mask[k]) return k;
    end
    return -1;
  endfunction

  int m_state[2];
  int m_ptr[2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w;
      if (rst) begin
        m_state[d] = 4356;
        m_ptr[d]   = N - 1;
      end else if (m_valid) begin
        w = winner(m_ptr[d], req_i, mask_i, seed_valid_i);
        if (seed_valid_i) m_state[d] = int'(seed_i);
        else if (w >= 0 || d == 1) m_state[d] = next_model(m_state[d]);
        if (w >= 0) m_ptr[d] = w;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare of both DUTs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        int           w;
        logic [N-1:0] eg;
        w  = winner(m_ptr[d], req_i, mask_i, seed_valid_i);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        check($sformatf("model.gnt%0d", d), int'(d == 0 ? gnt0 : gnt1), int'(eg));
        check($sformatf("model.busy%0d", d), int'(d == 0 ? busy0 : busy1), int'(w >= 0));
        check($sformatf("model.rnd%0d", d), int'(d == 0 ? rnd0 : rnd1), f_model(m_state[d]));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] order [6];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;
    rst = 1'b1; req_i = '0; mask_i = '0; seed_valid_i = 1'b0; seed_i = '0;
    tick();
    do_reset();

    // Idle after reset: rnd holds f(SEED)=41, no grants.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle.rnd0", int'(rnd0), 8'h41);
      check("idle.gnt0", int'(gnt0), 0);
      tick();
    end

    // Single requester, two consecutive bytes.
    req_i = 3'b001;
    @(negedge clk);
    check("one.gnt_a", int'(gnt0), 3'b001);
    check("one.rnd_a", int'(rnd0), 8'h41);
    tick();
    @(negedge clk);
    check("one.gnt_b", int'(gnt0), 3'b001);
    check("one.rnd_b", int'(rnd0), 8'hA0);
    tick();
    req_i = '0;

    // Full contention from a fresh reset.
    do_reset();
    req_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr.order", int'(gnt0), int'(order[i]));
      tick();
    end

    // Reseed blocks the grant for one cycle.
    req_i = 3'b010; seed_valid_i = 1'b1; seed_i = 16'd4356;
    @(negedge clk);
    check("reseed.gnt", int'(gnt0), 0);
    check("reseed.busy", int'(busy0), 0);
    tick();
    seed_valid_i = 1'b0;
    @(negedge clk);
    check("reseed.gnt_next", int'(gnt0), 3'b010);
    check("reseed.rnd0", int'(rnd0), 8'h41);
    check("reseed.rnd1", int'(rnd1), 8'h41);
    tick();

    // Masking.
    mask_i = 3'b001; req_i = 3'b011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mask.gnt", int'(gnt0), 3'b010);
      tick();
    end
    mask_i = 3'b111;
    @(negedge clk);
    check("mask_all.gnt", int'(gnt0), 0);
    check("mask_all.busy", int'(busy0), 0);
    tick();
    mask_i = '0;

    // Reset mid-stream with requests active.
    req_i = 3'b111;
    tick();
    do_reset();
    @(negedge clk);
    check("midrst.gnt", int'(gnt0), 3'b001);
    check("midrst.rnd", int'(rnd0), 8'h41);
    tick();

    // FREE_RUN advances on the idle cycle; FREE_RUN=0 does not.
    req_i = '0;
    do_reset();
    tick();
    req_i = 3'b001;
    @(negedge clk);
    check("free.rnd1", int'(rnd1), 8'hA0);
    check("free.rnd0", int'(rnd0), 8'h41);
    tick();

    // Randomised traffic with occasional reseeds and resets.
    for (int i = 0; i < 400; i++) begin
      req_i        = N'($urandom);
      mask_i       = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      seed_valid_i = ($urandom_range(15) == 0);
      seed_i       = 16'($urandom);
      rst          = ($urandom_range(63) == 0);
      tick();
    end
    rst = 1'b0; req_i = '0; seed_valid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
